control_sequencer: RTL and testbench

Microcoded control unit for the 8-bit CPU. It runs the fetch/execute T-state counter and decodes the instruction-register opcode and ALU flags into the per-step control word. That control word includes `ce` (increment) and `j` (load from bus), which drive the 4-bit program counter directly downstream. Each instruction ends early after its last micro-step, and HLT freezes the machine until reset.

---
 rtl/control_sequencer.sv | 128 ++++++++++++
 tb/tb_control_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Microcoded control unit: fetch/execute T-state counter plus combinational
// control-word decode of opcode, step and ALU flags. HLT latches until clr.
module control_sequencer (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  input  logic       cf,
  input  logic       zf,
  output logic [2:0] step,
  output logic       hlt,
  output logic       mi,
  output logic       ri,
  output logic       ro,
  output logic       io,
  output logic       ii,
  output logic       ai,
  output logic       ao,
  output logic       eo,
  output logic       su,
  output logic       bi,
  output logic       oi,
  output logic       ce,
  output logic       co,
  output logic       j,
  output logic       fi
);

  typedef enum logic [2:0] {T0, T1, T2, T3, T4} tstate_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } op_t;

  tstate_t state;
  tstate_t last_step;
  tstate_t next_state;
  logic    halted;

  assign step = state;

  always_comb begin
    case (opcode)
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = T2;
      OP_LDA, OP_STA:                               last_step = T3;
      OP_ADD, OP_SUB:                               last_step = T4;
      default:                                      last_step = T1;
    endcase
  end

  always_comb begin
    case (state)
      T0:      next_state = T1;
      T1:      next_state = T2;
      T2:      next_state = T3;
      T3:      next_state = T4;
      default: next_state = T0;
    endcase
  end

  // ">=" rather than "==" so a live opcode change can never strand the counter past its last step.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= T0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (opcode == OP_HLT && state == T2)
        halted <= 1'b1;
      else if (state >= last_step)
        state <= T0;
      else
        state <= next_state;
    end
  end

  always_comb begin
    hlt = 1'b0; mi = 1'b0; ri = 1'b0; ro = 1'b0; io = 1'b0; ii = 1'b0;
    ai  = 1'b0; ao = 1'b0; eo = 1'b0; su = 1'b0; bi = 1'b0; oi = 1'b0;
    ce  = 1'b0; co = 1'b0; j  = 1'b0; fi = 1'b0;
    if (!clr) begin
      if (halted) begin
        hlt = 1'b1;
      end else begin
        case (state)
          T0: begin co = 1'b1; mi = 1'b1; end
          T1: begin ro = 1'b1; ii = 1'b1; ce = 1'b1; end
          T2: begin
            case (opcode)
              OP_LDA, OP_ADD, OP_SUB, OP_STA: begin io = 1'b1; mi = 1'b1; end
              OP_LDI: begin io = 1'b1; ai = 1'b1; end
              OP_JMP: begin io = 1'b1; j = 1'b1; end
              OP_JC:  begin io = 1'b1; j = cf; end
              OP_JZ:  begin io = 1'b1; j = zf; end
              OP_OUT: begin ao = 1'b1; oi = 1'b1; end
              OP_HLT: hlt = 1'b1;
              default: ;
            endcase
          end
          T3: begin
            case (opcode)
              OP_LDA:         begin ro = 1'b1; ai = 1'b1; end
              OP_ADD, OP_SUB: begin ro = 1'b1; bi = 1'b1; end
              OP_STA:         begin ao = 1'b1; ri = 1'b1; end
              default: ;
            endcase
          end
          T4: begin
            if (opcode == OP_ADD || opcode == OP_SUB) begin
              eo = 1'b1; ai = 1'b1; fi = 1'b1;
              su = (opcode == OP_SUB);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed test-plan sequence, then random
// instructions, halts and clr pulses against a microprogram-table model.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] opcode;
  logic       cf, zf;
  logic [2:0] step;
  logic hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;
  logic [15:0] dut_word;

  control_sequencer dut (
    .clk(clk), .clr(clr), .opcode(opcode), .cf(cf), .zf(zf), .step(step),
    .hlt(hlt), .mi(mi), .ri(ri), .ro(ro), .io(io), .ii(ii), .ai(ai), .ao(ao),
    .eo(eo), .su(su), .bi(bi), .oi(oi), .ce(ce), .co(co), .j(j), .fi(fi)
  );

  always #5 clk = ~clk;

  assign dut_word = {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi};

  localparam logic [15:0] B_HLT = 16'h8000, B_MI = 16'h4000, B_RI = 16'h2000,
                          B_RO  = 16'h1000, B_IO = 16'h0800, B_II = 16'h0400,
                          B_AI  = 16'h0200, B_AO = 16'h0100, B_EO = 16'h0080,
                          B_SU  = 16'h0040, B_BI = 16'h0020, B_OI = 16'h0010,
                          B_CE  = 16'h0008, B_CO = 16'h0004, B_J  = 16'h0002,
                          B_FI  = 16'h0001;

  logic [15:0] ucode [16][5];
  int unsigned ilen  [16];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int unsigned m_step;
  bit          m_halt;
  int unsigned halt_cycles;
  logic [5:0]  directed [$];
  logic [5:0]  ent;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_word(input logic [3:0] op, input int unsigned t,
                                           input logic c, input logic z,
                                           input bit halted, input logic rst);
    logic [15:0] w;
    if (rst) return 16'h0000;
    if (halted) return B_HLT;
    w = ucode[op][t];
    if (t == 2 && ((op == 4'h7 && c) || (op == 4'h8 && z))) w |= B_J;
    return w;
  endfunction

  initial begin
    for (int unsigned op = 0; op < 16; op++) begin
      ucode[op][0] = B_CO | B_MI;
      ucode[op][1] = B_RO | B_II | B_CE;
      ucode[op][2] = '0; ucode[op][3] = '0; ucode[op][4] = '0;
      ilen[op] = 2;
    end
    ucode[1][2] = B_IO | B_MI; ucode[1][3] = B_RO | B_AI; ilen[1] = 4;
    ucode[2][2] = B_IO | B_MI; ucode[2][3] = B_RO | B_BI;
    ucode[2][4] = B_EO | B_AI | B_FI; ilen[2] = 5;
    ucode[3][2] = B_IO | B_MI; ucode[3][3] = B_RO | B_BI;
    ucode[3][4] = B_EO | B_AI | B_FI | B_SU; ilen[3] = 5;
    ucode[4][2] = B_IO | B_MI; ucode[4][3] = B_AO | B_RI; ilen[4] = 4;
    ucode[5][2] = B_IO | B_AI; ilen[5] = 3;
    ucode[6][2] = B_IO | B_J;  ilen[6] = 3;
    ucode[7][2] = B_IO;        ilen[7] = 3;
    ucode[8][2] = B_IO;        ilen[8] = 3;
    ucode[14][2] = B_AO | B_OI; ilen[14] = 3;
    ucode[15][2] = B_HLT;      ilen[15] = 3;

    // {cf, zf, opcode}
    directed = '{6'h05, 6'h02, 6'h07, 6'h27, 6'h03, 6'h18, 6'h00, 6'h0B,
                 6'h01, 6'h04, 6'h06, 6'h0E, 6'h0F};

    clr = 1'b1; opcode = 4'h0; cf = 1'b0; zf = 1'b0;
    m_step = 0; m_halt = 1'b0; halt_cycles = 0;
    repeat (2) begin
      @(negedge clk);
      check("reset step", {13'b0, step}, 16'h0000);
      check("reset word", dut_word, 16'h0000);
    end

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      if (clr) begin
        m_step = 0; m_halt = 1'b0;
      end else if (!m_halt) begin
        if (opcode == 4'hF && m_step == 2) m_halt = 1'b1;
        else if (m_step == ilen[opcode] - 1) m_step = 0;
        else m_step++;
      end
      #1;
      if (clr) begin
        clr = 1'b0;
      end else if (m_halt) begin
        halt_cycles++;
        opcode = 4'($urandom); cf = 1'($urandom); zf = 1'($urandom);
        if (halt_cycles >= 12 + (directed.size() == 0 ? $urandom_range(0, 8) : 0)) begin
          clr = 1'b1; halt_cycles = 0;
        end
      end else if (directed.size() == 0 && $urandom_range(0, 49) == 0) begin
        clr = 1'b1;
      end
      if (!clr && !m_halt && m_step == 0) begin
        if (directed.size() != 0) ent = directed.pop_front();
        else ent = 6'($urandom);
        {cf, zf, opcode} = ent;
      end
      @(negedge clk);
      check($sformatf("step op=%h", opcode), {13'b0, step},
            clr ? 16'h0000 : 16'(m_step));
      check($sformatf("word op=%h t=%0d", opcode, m_step), dut_word,
            ref_word(opcode, m_step, cf, zf, m_halt, clr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
